arith_enc_result_checker: RTL and testbench

- Parametrised, self-checking result checker for the arithmetic encoder pipeline.
- Receives each symbol's expected range/low in the same cycle the symbol is presented to the encoder, delays them by a configurable pipeline latency, and compares them against the encoder's RANGE_OUTPUT/LOW_OUTPUT.
- Counts mismatches and captures the first failure for CSV-driven benches and on-board regression.
- Adds valid-qualified issue, bubbles, end-of-stream drain and done signalling.

---
 rtl/arith_chk_pkg.sv | 20 ++
 rtl/arith_chk_delay_line.sv | 51 +++++
 rtl/arith_enc_result_checker.sv | 167 ++++++++++++++++
 tb/tb_arith_enc_result_checker.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_chk_pkg.sv
// Shared types and helpers for the arithmetic-encoder result checker.
package arith_chk_pkg;

    localparam int MAX_LATENCY = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

// File: rtl/arith_chk_delay_line.sv
// Expected-value delay line: LATENCY stages, MSB of each entry is its valid bit.
module arith_chk_delay_line #(
    parameter int LATENCY = 3,
    parameter int WIDTH   = 8
) (
    input  logic             general_clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] entry_in,
    output logic [WIDTH-1:0] entry_out,
    output logic             any_valid
);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [WIDTH-2:0]   data_q [LATENCY];
    logic [WIDTH-2:0]   data_d [LATENCY];
    logic               any_valid_q, any_valid_d;

    always_comb begin
        valid_d    = '0;
        valid_d[0] = entry_in[WIDTH-1];
        data_d[0]  = entry_in[WIDTH-2:0];
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
        if (clear) begin
            valid_d = '0;
        end
        any_valid_d = |valid_d;
    end

    always_ff @(posedge general_clk or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            any_valid_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            any_valid_q <= any_valid_d;
        end
    end

    // NOTE: payload flops carry no reset; the valid bits alone decide whether a stage means anything.
    always_ff @(posedge general_clk) begin
        data_q <= data_d;
    end

    assign entry_out = {valid_q[LATENCY-1], data_q[LATENCY-1]};
    assign any_valid = any_valid_q;

endmodule

// File: rtl/arith_enc_result_checker.sv
// Delays expected range/low by the encoder latency and scores the encoder outputs.
// Build option ARITH_CHK_HALT_ON_ERR_EN: stop checking and go DONE on the first mismatch.
module arith_enc_result_checker
    import arith_chk_pkg::*;
#(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 24,
    parameter int LATENCY     = 3,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   general_clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [RANGE_WIDTH-1:0] exp_range,
    input  logic [LOW_WIDTH-1:0]   exp_low,
    input  logic                   flush,
    input  logic [RANGE_WIDTH-1:0] dut_range,
    input  logic [LOW_WIDTH-1:0]   dut_low,
    output logic [CNT_WIDTH-1:0]   checked_cnt,
    output logic [CNT_WIDTH-1:0]   range_err_cnt,
    output logic [CNT_WIDTH-1:0]   low_err_cnt,
    output logic                   mismatch,
    output logic                   first_err_valid,
    output logic [CNT_WIDTH-1:0]   first_err_index,
    output logic [RANGE_WIDTH-1:0] first_err_range,
    output logic [LOW_WIDTH-1:0]   first_err_low,
    output logic                   chk_done
);

    typedef struct packed {
        logic                   valid;
        logic [RANGE_WIDTH-1:0] range;
        logic [LOW_WIDTH-1:0]   low;
        logic [CNT_WIDTH-1:0]   index;
    } chk_entry_t;

    localparam int ENTRY_W = $bits(chk_entry_t);

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
        logic [63:0] wide;
        wide = sat_inc(64'(v), CNT_WIDTH);
        return wide[CNT_WIDTH-1:0];
    endfunction

    chk_state_t             state_q, state_d;
    logic [CNT_WIDTH-1:0]   idx_q, idx_d;
    logic [CNT_WIDTH-1:0]   checked_q, checked_d;
    logic [CNT_WIDTH-1:0]   range_err_q, range_err_d;
    logic [CNT_WIDTH-1:0]   low_err_q, low_err_d;
    logic                   mismatch_q, mismatch_d;
    logic                   first_valid_q, first_valid_d;
    logic [CNT_WIDTH-1:0]   first_idx_q, first_idx_d;
    logic [RANGE_WIDTH-1:0] first_range_q, first_range_d;
    logic [LOW_WIDTH-1:0]   first_low_q, first_low_d;

    chk_entry_t entry_in, entry_out;
    logic       accept, any_valid, do_cmp, range_bad, low_bad, any_bad, halt;

    assign accept = in_valid && ((state_q == IDLE) || (state_q == RUN));

    always_comb begin
        entry_in.valid = accept;
        entry_in.range = exp_range;
        entry_in.low   = exp_low;
        entry_in.index = idx_q;
    end

    arith_chk_delay_line #(
        .LATENCY (LATENCY),
        .WIDTH   (ENTRY_W)
    ) u_delay_line (
        .general_clk (general_clk),
        .reset       (reset),
        .clear       (halt),
        .entry_in    (entry_in),
        .entry_out   (entry_out),
        .any_valid   (any_valid)
    );

    assign do_cmp    = entry_out.valid && (state_q != DONE);
    assign range_bad = do_cmp && (dut_range != entry_out.range);
    assign low_bad   = do_cmp && (dut_low != entry_out.low);
    assign any_bad   = range_bad || low_bad;

`ifdef ARITH_CHK_HALT_ON_ERR_EN
    assign halt = any_bad;
`else
    assign halt = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = (in_valid || any_valid) ? DRAIN : DONE;
                end else if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   if (!any_valid) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (halt) begin
            state_d = DONE;
        end
    end

    always_comb begin
        idx_d         = accept ? cnt_inc(idx_q) : idx_q;
        checked_d     = do_cmp ? cnt_inc(checked_q) : checked_q;
        range_err_d   = range_bad ? cnt_inc(range_err_q) : range_err_q;
        low_err_d     = low_bad ? cnt_inc(low_err_q) : low_err_q;
        mismatch_d    = any_bad;
        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        first_range_d = first_range_q;
        first_low_d   = first_low_q;
        if (any_bad && !first_valid_q) begin
            first_valid_d = 1'b1;
            first_idx_d   = entry_out.index;
            first_range_d = dut_range;
            first_low_d   = dut_low;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge general_clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            checked_q     <= '0;
            range_err_q   <= '0;
            low_err_q     <= '0;
            mismatch_q    <= 1'b0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            first_range_q <= '0;
            first_low_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            checked_q     <= checked_d;
            range_err_q   <= range_err_d;
            low_err_q     <= low_err_d;
            mismatch_q    <= mismatch_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
            first_range_q <= first_range_d;
            first_low_q   <= first_low_d;
        end
    end

    assign checked_cnt     = checked_q;
    assign range_err_cnt   = range_err_q;
    assign low_err_cnt     = low_err_q;
    assign mismatch        = mismatch_q;
    assign first_err_valid = first_valid_q;
    assign first_err_index = first_idx_q;
    assign first_err_range = first_range_q;
    assign first_err_low   = first_low_q;
    assign chk_done        = (state_q == DONE);

endmodule

// File: tb/tb_arith_enc_result_checker.sv
// Directed bench: main checker (LATENCY=3) plus CNT_WIDTH=4 copies at LATENCY 3, 1 and 16.
module tb_arith_enc_result_checker;

    typedef struct packed {
        logic        v;
        logic [15:0] r;
        logic [23:0] l;
        logic [15:0] rx;
        logic [23:0] lx;
    } hist_t;

    typedef struct {
        string       name;
        logic [31:0] pat;
        int          n;
        int          lo_idx;
        int          ra_idx;
        bit          all_err;
        int          exp_checked;
        int          exp_rerr;
        int          exp_lerr;
        int          exp_pulses;
        bit          exp_fv;
        int          exp_fidx;
        logic [15:0] exp_frange;
        logic [23:0] exp_flow;
        int          exp_lat;
        bit          chk_sat;
        int          exp_sat;
    } row_t;

    localparam int SAT_LAT [3] = '{3, 1, 16};

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] exp_range;
    logic [23:0] exp_low;
    logic        flush;
    logic [15:0] cur_rx;
    logic [23:0] cur_lx;

    hist_t       hist [arith_chk_pkg::MAX_LATENCY];
    logic [15:0] st_r [arith_chk_pkg::MAX_LATENCY];
    logic [23:0] st_l [arith_chk_pkg::MAX_LATENCY];

    logic [31:0] m_checked, m_rerr, m_lerr, m_fidx;
    logic        m_mm, m_fv, m_done;
    logic [15:0] m_frange;
    logic [23:0] m_flow;

    logic [3:0]  s_checked [3];
    logic [3:0]  s_rerr [3];
    logic [3:0]  s_lerr [3];
    logic [3:0]  s_fidx [3];
    logic [15:0] s_frange [3];
    logic [23:0] s_flow [3];
    logic [2:0]  s_mm, s_fv, s_done;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    row_t rows [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder stub: replays the issued expected values LATENCY edges later, optionally corrupted.
    always @(posedge clk) begin
        hist[0] <= '{in_valid, exp_range, exp_low, cur_rx, cur_lx};
        for (int i = 1; i < arith_chk_pkg::MAX_LATENCY; i++) hist[i] <= hist[i-1];
    end

    always_comb begin
        for (int i = 0; i < arith_chk_pkg::MAX_LATENCY; i++) begin
            st_r[i] = hist[i].v ? (hist[i].r ^ hist[i].rx) : ~hist[i].r;
            st_l[i] = hist[i].v ? (hist[i].l ^ hist[i].lx) : ~hist[i].l;
        end
    end

    always @(negedge clk) if (m_mm === 1'b1) pulses <= pulses + 1;

    arith_enc_result_checker #(
        .RANGE_WIDTH(16), .LOW_WIDTH(24), .LATENCY(3), .CNT_WIDTH(32)
    ) u_dut (
        .general_clk     (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .exp_range       (exp_range),
        .exp_low         (exp_low),
        .flush           (flush),
        .dut_range       (st_r[2]),
        .dut_low         (st_l[2]),
        .checked_cnt     (m_checked),
        .range_err_cnt   (m_rerr),
        .low_err_cnt     (m_lerr),
        .mismatch        (m_mm),
        .first_err_valid (m_fv),
        .first_err_index (m_fidx),
        .first_err_range (m_frange),
        .first_err_low   (m_flow),
        .chk_done        (m_done)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sat
        arith_enc_result_checker #(
            .RANGE_WIDTH(16), .LOW_WIDTH(24), .LATENCY(SAT_LAT[g]), .CNT_WIDTH(4)
        ) u_sat (
            .general_clk     (clk),
            .reset           (reset),
            .in_valid        (in_valid),
            .exp_range       (exp_range),
            .exp_low         (exp_low),
            .flush           (flush),
            .dut_range       (st_r[SAT_LAT[g]-1]),
            .dut_low         (st_l[SAT_LAT[g]-1]),
            .checked_cnt     (s_checked[g]),
            .range_err_cnt   (s_rerr[g]),
            .low_err_cnt     (s_lerr[g]),
            .mismatch        (s_mm[g]),
            .first_err_valid (s_fv[g]),
            .first_err_index (s_fidx[g]),
            .first_err_range (s_frange[g]),
            .first_err_low   (s_flow[g]),
            .chk_done        (s_done[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        flush     = 1'b0;
        exp_range = 16'hDEAD;
        exp_low   = 24'hBEEF00;
        cur_rx    = '0;
        cur_lx    = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive(input bit v, input bit f, input int idx,
                         input logic [15:0] rx, input logic [23:0] lx);
        @(negedge clk);
        in_valid  = v;
        flush     = f;
        exp_range = v ? 16'h8000 - 16'(idx) : 16'hDEAD;
        exp_low   = v ? 24'h000451 + 24'(idx) : 24'hBEEF00;
        cur_rx    = rx;
        cur_lx    = lx;
    endtask

    // Waits (bounded) after the flush edge; lat = edges from flush to chk_done.
    task automatic wait_done(output int lat);
        lat = -1;
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            if (lat < 0 && m_done) lat = k;
            if (m_done && (&s_done)) break;
        end
    endtask

    initial begin
        int          lat, idx, p0;
        bit          v;
        logic [15:0] rx;
        logic [23:0] lx;

        rows[0] = '{"stream10", 32'h3FF, 10, -1, -1, 1'b0, 10, 0, 0, 0, 1'b0, 0, 16'h0, 24'h0, 4, 1'b0, 0};
        rows[1] = '{"bubbles", 32'h2D, 6, -1, -1, 1'b0, 4, 0, 0, 0, 1'b0, 0, 16'h0, 24'h0, 4, 1'b0, 0};
        rows[2] = '{"flush_bubble", 32'h3, 3, -1, -1, 1'b0, 2, 0, 0, 0, 1'b0, 0, 16'h0, 24'h0, 3, 1'b0, 0};
`ifdef ARITH_CHK_HALT_ON_ERR_EN
        rows[3] = '{"inject", 32'h3FF, 10, 5, 7, 1'b0, 6, 0, 1, 1, 1'b1, 5, 16'h7FFB, 24'h000123, -1, 1'b0, 0};
        rows[4] = '{"saturate", 32'hFFFFF, 20, -1, -1, 1'b1, 1, 1, 1, 1, 1'b1, 0, 16'h8001, 24'h000450, -1, 1'b1, 1};
`else
        rows[3] = '{"inject", 32'h3FF, 10, 5, 7, 1'b0, 10, 1, 1, 2, 1'b1, 5, 16'h7FFB, 24'h000123, 4, 1'b0, 0};
        rows[4] = '{"saturate", 32'hFFFFF, 20, -1, -1, 1'b1, 20, 20, 20, 20, 1'b1, 0, 16'h8001, 24'h000450, 4, 1'b1, 15};
`endif

        reset = 1'b1;
        idle_inputs();
        do_reset();
        check("rst checked", 64'(m_checked), 0);
        check("rst range_err", 64'(m_rerr), 0);
        check("rst low_err", 64'(m_lerr), 0);
        check("rst mismatch", 64'(m_mm), 0);
        check("rst first_valid", 64'(m_fv), 0);
        check("rst first_index", 64'(m_fidx), 0);
        check("rst done", 64'(m_done), 0);

        foreach (rows[r]) begin
            do_reset();
            p0  = pulses;
            idx = 0;
            for (int i = 0; i < rows[r].n; i++) begin
                v  = rows[r].pat[i];
                rx = (v && (rows[r].all_err || idx == rows[r].ra_idx)) ? 16'h0001 : 16'h0;
                lx = (v && idx == rows[r].lo_idx) ? (24'h000456 ^ 24'h000123) :
                     (v && rows[r].all_err) ? 24'h000001 : 24'h0;
                drive(v, i == rows[r].n - 1, idx, rx, lx);
                if (v) idx++;
            end
            wait_done(lat);
            check({rows[r].name, " done"}, 64'(m_done), 1);
            if (rows[r].exp_lat >= 0) check({rows[r].name, " done latency"}, 64'(lat), 64'(rows[r].exp_lat));
            check({rows[r].name, " checked"}, 64'(m_checked), 64'(rows[r].exp_checked));
            check({rows[r].name, " range_err"}, 64'(m_rerr), 64'(rows[r].exp_rerr));
            check({rows[r].name, " low_err"}, 64'(m_lerr), 64'(rows[r].exp_lerr));
            check({rows[r].name, " mismatch pulses"}, 64'(pulses - p0), 64'(rows[r].exp_pulses));
            check({rows[r].name, " first_valid"}, 64'(m_fv), 64'(rows[r].exp_fv));
            if (rows[r].exp_fv) begin
                check({rows[r].name, " first_index"}, 64'(m_fidx), 64'(rows[r].exp_fidx));
                check({rows[r].name, " first_range"}, 64'(m_frange), 64'(rows[r].exp_frange));
                check({rows[r].name, " first_low"}, 64'(m_flow), 64'(rows[r].exp_flow));
            end
            if (rows[r].chk_sat) begin
                for (int g = 0; g < 3; g++) begin
                    check($sformatf("%s L%0d checked", rows[r].name, SAT_LAT[g]), 64'(s_checked[g]), 64'(rows[r].exp_sat));
                    check($sformatf("%s L%0d range_err", rows[r].name, SAT_LAT[g]), 64'(s_rerr[g]), 64'(rows[r].exp_sat));
                    check($sformatf("%s L%0d low_err", rows[r].name, SAT_LAT[g]), 64'(s_lerr[g]), 64'(rows[r].exp_sat));
                end
            end
        end

        // Flush in IDLE with nothing in flight, then in_valid must be ignored in DONE.
        do_reset();
        drive(1'b0, 1'b1, 0, 16'h0, 24'h0);
        @(negedge clk);
        idle_inputs();
        check("idle_flush done", 64'(m_done), 1);
        check("idle_flush checked", 64'(m_checked), 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, i, 16'h0001, 24'h0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 0, 16'h0, 24'h0);
        check("done_ignores checked", 64'(m_checked), 0);
        check("done_ignores range_err", 64'(m_rerr), 0);
        check("done_sticky", 64'(m_done), 1);

        // Reset with two corrupt entries in flight, then three clean symbols.
        do_reset();
        p0 = pulses;
        drive(1'b1, 1'b0, 0, 16'h0001, 24'h000001);
        drive(1'b1, 1'b0, 1, 16'h0001, 24'h000001);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, i == 2, i, 16'h0, 24'h0);
        wait_done(lat);
        check("midreset done", 64'(m_done), 1);
        check("midreset checked", 64'(m_checked), 3);
        check("midreset range_err", 64'(m_rerr), 0);
        check("midreset low_err", 64'(m_lerr), 0);
        check("midreset pulses", 64'(pulses - p0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
